// File: rtl/pipe_stage_pkg.sv
// Shared constants and types for the pipe_stage register slice.
// Constant names and values mirror the processor-wide defines so bubbles look identical everywhere.
package pipe_stage_pkg;

   localparam logic [4:0]  NOPRegAddr     = 5'b00000;
   localparam logic        WriteDisable   = 1'b0;
   localparam logic        NotInDelaySlot = 1'b0;
   localparam logic [31:0] ZeroWord       = 32'h0000_0000;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_stage_cnt.sv
// Saturating event counter; a clear on the same cycle as an increment wins.
module pipe_stage_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register slice between decode and execute: single register or 2-entry skid buffer,
// with bubble forcing on the control fields and stall/bubble performance counters.
module pipe_stage
   import pipe_stage_pkg::*;
#(
   parameter int DATA_W  = 75,
   parameter int WD_W    = 5,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cnt_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [WD_W-1:0]   in_wd,
   input  logic              in_wreg,
   input  logic              in_dslot,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [WD_W-1:0]   out_wd,
   output logic              out_wreg,
   output logic              out_dslot,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [WD_W-1:0]   wd;
      logic              wreg;
      logic              dslot;
   } entry_t;

   entry_t main_q;
   entry_t skid_q;
   entry_t in_ent;
   logic   main_valid;
   logic   skid_valid;
   logic   accept;
   logic   retire;
   occ_e   occ;

   assign in_ent = '{data: in_data, wd: in_wd, wreg: in_wreg, dslot: in_dslot};
   assign accept = in_valid & in_ready;
   assign retire = main_valid & out_ready;

   generate
      if (SKID_EN != 0) begin : g_skid
         logic skid_nxt;
         logic ready_q;

         // skid only fills when main is busy and not draining; it empties into main on retire
         always_comb begin
            skid_nxt = skid_valid;
            if (flush) begin
               skid_nxt = 1'b0;
            end else if (skid_valid) begin
               if (retire) skid_nxt = 1'b0;
            end else if (accept && main_valid && !retire) begin
               skid_nxt = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
               skid_q     <= '0;
            end else begin
               skid_valid <= skid_nxt;
               ready_q    <= !skid_nxt;
               if (!skid_valid && accept) skid_q <= in_ent;
            end
         end

         // registered so out_ready never reaches upstream combinationally
         assign in_ready = ready_q;
      end else begin : g_reg
         assign skid_valid = 1'b0;
         assign skid_q     = '0;
         assign in_ready   = !main_valid | out_ready;
      end
   endgenerate

   // main is the head; it keeps its payload while empty so out_data holds through bubbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid <= 1'b0;
         main_q     <= '{data: DATA_W'(ZeroWord), wd: WD_W'(NOPRegAddr),
                         wreg: WriteDisable, dslot: NotInDelaySlot};
      end else if (flush) begin
         main_valid <= 1'b0;
      end else if (retire && skid_valid) begin
         main_q     <= skid_q;
      end else if (accept && (!main_valid || retire)) begin
         main_valid <= 1'b1;
         main_q     <= in_ent;
      end else if (retire) begin
         main_valid <= 1'b0;
      end
   end

   assign out_valid = main_valid;
   assign out_data  = main_q.data;
   assign out_wd    = main_valid ? main_q.wd    : WD_W'(NOPRegAddr);
   assign out_wreg  = main_valid ? main_q.wreg  : WriteDisable;
   assign out_dslot = main_valid ? main_q.dslot : NotInDelaySlot;

   always_comb begin
      occ = OCC_EMPTY;
      if (main_valid && skid_valid) occ = OCC_TWO;
      else if (main_valid)          occ = OCC_ONE;
   end
   assign occupancy = occ;

   pipe_stage_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (main_valid & !out_ready),
      .clr (cnt_clr),
      .cnt (stall_cnt)
   );

   pipe_stage_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!main_valid),
      .clr (cnt_clr),
      .cnt (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: register mode (index 0) and skid mode with 4-bit counters (index 1)
// share stimulus; each is compared against a queue-level model of its capacity rules.
module tb_pipe_stage;

   localparam int DW = 75;
   localparam int WW = 5;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [WW-1:0] wd;
      logic          wreg;
      logic          dslot;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          cnt_clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [WW-1:0] in_wd = '0;
   logic          in_wreg = 1'b0;
   logic          in_dslot = 1'b0;

   logic          ov[2], ir[2], owr[2], ods[2];
   logic [DW-1:0] od[2];
   logic [WW-1:0] ow[2];
   logic [1:0]    occ[2];
   logic [15:0]   sc0, bc0;
   logic [3:0]    sc1, bc1;

   ent_t          mq[2][2];
   int            msz[2];
   logic [DW-1:0] mlast[2];
   int            mstall[2], mbub[2];
   int            cmax[2] = '{65535, 15};

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipe_stage #(.DATA_W(DW), .WD_W(WW), .SKID_EN(0), .CNT_W(16)) u_reg (
      .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_wd(in_wd),
      .in_wreg(in_wreg), .in_dslot(in_dslot),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_wd(ow[0]),
      .out_wreg(owr[0]), .out_dslot(ods[0]), .occupancy(occ[0]),
      .stall_cnt(sc0), .bubble_cnt(bc0)
   );

   pipe_stage #(.DATA_W(DW), .WD_W(WW), .SKID_EN(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_wd(in_wd),
      .in_wreg(in_wreg), .in_dslot(in_dslot),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_wd(ow[1]),
      .out_wreg(owr[1]), .out_dslot(ods[1]), .occupancy(occ[1]),
      .stall_cnt(sc1), .bubble_cnt(bc1)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic mready(int m);
      if (m == 1) return msz[1] < 2;
      return (msz[0] == 0) || out_ready;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         msz[m] = 0; mlast[m] = '0; mstall[m] = 0; mbub[m] = 0;
      end
   endtask

   task automatic check_all(input int m);
      logic v;
      v = msz[m] > 0;
      chk($sformatf("out_valid%0d", m), ov[m], v);
      chk($sformatf("out_data%0d", m), od[m], v ? mq[m][0].d : mlast[m]);
      chk($sformatf("out_wd%0d", m), ow[m], v ? mq[m][0].wd : '0);
      chk($sformatf("out_wreg%0d", m), owr[m], v ? mq[m][0].wreg : 1'b0);
      chk($sformatf("out_dslot%0d", m), ods[m], v ? mq[m][0].dslot : 1'b0);
      chk($sformatf("occupancy%0d", m), occ[m], msz[m]);
      chk($sformatf("in_ready%0d", m), ir[m], mready(m));
      chk($sformatf("stall_cnt%0d", m), m ? 16'(sc1) : sc0, mstall[m]);
      chk($sformatf("bubble_cnt%0d", m), m ? 16'(bc1) : bc0, mbub[m]);
   endtask

   // Drive one cycle from a negedge, advance the model across the posedge, check at the next negedge.
   task automatic step(input logic v, input logic r, input logic f, input logic c,
                       input logic [DW-1:0] d);
      logic acc[2], ret[2], stl[2], bub[2];
      ent_t e;
      in_valid = v; out_ready = r; flush = f; cnt_clr = c; in_data = d;
      in_wd = WW'($urandom); in_wreg = 1'($urandom); in_dslot = 1'($urandom);
      e = '{d: d, wd: in_wd, wreg: in_wreg, dslot: in_dslot};
      for (int m = 0; m < 2; m++) begin
         acc[m] = v && mready(m);
         ret[m] = (msz[m] > 0) && r;
         stl[m] = (msz[m] > 0) && !r;
         bub[m] = msz[m] == 0;
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (f) begin
            msz[m] = 0;
         end else begin
            if (ret[m]) begin mq[m][0] = mq[m][1]; msz[m]--; end
            if (acc[m]) begin mq[m][msz[m]] = e; msz[m]++; end
         end
         if (msz[m] > 0) mlast[m] = mq[m][0].d;
         if (c) mstall[m] = 0; else if (stl[m] && mstall[m] < cmax[m]) mstall[m]++;
         if (c) mbub[m] = 0;   else if (bub[m] && mbub[m] < cmax[m])   mbub[m]++;
      end
      @(negedge clk);
      check_all(0);
      check_all(1);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return DW'({$urandom, $urandom, $urandom});
   endfunction

   initial begin
      logic [DW-1:0] a, b, cc, dd;
      model_reset();
      repeat (2) @(negedge clk);
      check_all(0);
      check_all(1);
      rst = 1'b1;

      // back-to-back stream with out_ready high
      for (int i = 1; i <= 3; i++) begin
         step(1, 1, 0, 0, DW'(i));
         chk("stream_data", od[1], DW'(i));
         chk("stream_occ", occ[1], 2'd1);
      end
      step(0, 1, 0, 0, '0);
      chk("bubble_valid", ov[1], 1'b0);
      chk("bubble_hold_data", od[1], DW'(3));

      // backpressure: B into skid, C held upstream
      a = rnd_data(); b = rnd_data(); cc = rnd_data(); dd = rnd_data();
      step(0, 1, 0, 1, '0);
      step(1, 0, 0, 0, a);
      step(1, 0, 0, 0, b);
      step(1, 0, 0, 0, cc);
      step(1, 0, 0, 0, cc);
      chk("bp_stall", sc1, 4'd3);
      chk("bp_ready", ir[1], 1'b0);
      chk("bp_occ", occ[1], 2'd2);
      chk("bp_head", od[1], a);
      step(1, 1, 0, 0, cc);
      chk("bp_out_b", od[1], b);
      step(1, 1, 0, 0, cc);
      chk("bp_out_c", od[1], cc);
      step(0, 1, 0, 0, '0);

      // flush with both entries held and a new offer on the same edge
      step(1, 0, 0, 0, a);
      step(1, 0, 0, 0, b);
      chk("fl_pre_occ", occ[1], 2'd2);
      step(1, 0, 1, 0, dd);
      chk("fl_occ", occ[1], 2'd0);
      chk("fl_valid", ov[1], 1'b0);
      chk("fl_ready", ir[1], 1'b1);
      repeat (2) begin
         step(0, 1, 0, 0, '0);
         chk("fl_no_ghost", ov[1], 1'b0);
      end

      // stall counter saturation and clear-wins
      step(1, 0, 0, 0, a);
      repeat (20) step(0, 0, 0, 0, '0);
      chk("sat_stall", sc1, 4'd15);
      step(0, 0, 0, 1, '0);
      chk("sat_clr", sc1, 4'd0);
      step(0, 1, 0, 0, '0);
      step(0, 1, 0, 0, '0);

      // asynchronous reset mid-stall with two entries held
      step(1, 0, 0, 0, a);
      step(1, 0, 0, 0, b);
      chk("ar_pre_occ", occ[1], 2'd2);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", ov[1], 1'b0);
      chk("ar_data", od[1], '0);
      chk("ar_wd", ow[1], '0);
      chk("ar_wreg", owr[1], 1'b0);
      chk("ar_dslot", ods[1], 1'b0);
      chk("ar_occ", occ[1], 2'd0);
      chk("ar_ready", ir[1], 1'b1);
      chk("ar_stall", sc1, 4'd0);
      chk("ar_bubble", bc1, 4'd0);
      chk("ar_valid_reg", ov[0], 1'b0);
      chk("ar_stall_reg", sc0, 16'd0);
      model_reset();
      @(negedge clk);
      check_all(0);
      check_all(1);
      rst = 1'b1;
      step(1, 0, 0, 0, cc);
      chk("ar_first_accept", od[1], cc);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 60),
              1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 3), rnd_data());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- DATA_W, 75: stage payload width (aluop+alusel+reg1+reg2).
- WD_W, 5: destination register address width.
- SKID_EN, 1: 1 selects a 2-entry skid buffer, 0 selects a single register.
- CNT_W, 16: width of the performance counters.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous reset, active-low (asserted at 0).
- flush, in, 1: synchronous kill of all held entries.
- cnt_clr, in, 1: synchronous clear of the counters.
- in_valid, in, 1: upstream entry valid.
- in_ready, out, 1: stage can accept.
- in_data, in, DATA_W: upstream payload.
- in_wd, in, WD_W: upstream destination address.
- in_wreg, in, 1: upstream write enable.
- in_dslot, in, 1: upstream in-delay-slot flag.
- out_valid, out, 1: downstream entry valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, DATA_W: downstream payload.
- out_wd, out, WD_W: downstream destination address.
- out_wreg, out, 1: downstream write enable.
- out_dslot, out, 1: downstream in-delay-slot flag.
- occupancy, out, 2: held entries, 0..2.
- stall_cnt, out, CNT_W: cycles with out_valid=1 and out_ready=0.
- bubble_cnt, out, CNT_W: cycles with out_valid=0.

Function
REQ-003 SHALL accept an entry when in_valid and in_ready are both 1 on a rising clk, and SHALL present it on out_* exactly 1 cycle later if the stage was empty.
REQ-004 SHALL retire the head entry when out_valid and out_ready are both 1.
REQ-005 SHALL preserve strict FIFO order and SHALL neither drop nor duplicate entries.
REQ-006 With SKID_EN=0, in_ready SHALL equal !out_valid | out_ready (combinational), and a simultaneous retire and accept SHALL replace the head in the same edge.
REQ-007 With SKID_EN=1, in_ready SHALL be a register output equal to !skid_valid, with no combinational path from out_ready.
REQ-008 With SKID_EN=1, an accept while the main entry is valid and not retiring SHALL load the skid entry; on retire, the skid entry SHALL move to main in the same edge.
REQ-009 When out_valid=0, the stage SHALL force out_wreg to WriteDisable, out_wd to NOPRegAddr and out_dslot to NotInDelaySlot (bubble); out_data SHALL hold its last value.
REQ-010 flush=1 SHALL invalidate both entries at the next edge, giving occupancy 0, out_valid 0 and in_ready 1; an in_valid presented on the same edge SHALL be discarded.
REQ-011 stall_cnt and bubble_cnt SHALL increment by 1 per qualifying cycle and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-012 When cnt_clr coincides with a qualifying cycle, the counter SHALL become 0 (clear wins).
REQ-013 occupancy SHALL be 0 when empty, 1 when main only is valid, and 2 when main and skid are valid; with SKID_EN=0 it SHALL never exceed 1.

Reset
REQ-014 While rst=0, asynchronously: out_valid=0, out_data=ZeroWord-extended 0, out_wd=NOPRegAddr, out_wreg=WriteDisable, out_dslot=NotInDelaySlot, skid_valid=0, occupancy=0, counters=0, and in_ready=1 (both modes).
REQ-015 A reset asserted mid-transfer SHALL discard all held entries, and the first accept after release SHALL follow REQ-003.

Structure
REQ-016 NOPRegAddr, WriteDisable, NotInDelaySlot and ZeroWord SHALL come from the shared defines.v; no new global constants SHALL be added.
REQ-017 The saturating counter SHALL be one sub-module, pipe_stage_cnt (parameter CNT_W; inputs inc and clr), instantiated twice.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- SKID_EN=1, out_ready=1, in_valid=1 with data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each; occupancy stays 1.
- SKID_EN=1, accept A, then hold out_ready=0 for 3 cycles while offering B, C -> B goes to skid, in_ready=0, C is held upstream, stall_cnt=3; release -> out sequence A, B, C.
- Idle cycle after retire -> out_valid=0, out_wreg=0, out_wd=0, out_dslot=0, out_data unchanged, bubble_cnt+1.
- occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, offered entry never appears.
- CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr on a stall cycle -> 0.
- rst=0 asserted asynchronously mid-stall with occupancy=2 -> all outputs take REQ-014 values before the next clk edge.
